// File: rtl/keylock_pkg.sv
// Shared constants for the keypad lock: state codes, command keys and small helpers.
package keylock_pkg;

    localparam int CODE_W  = 32;
    localparam int TIMER_W = 26;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_CHECK        = 3'd1;
    localparam logic [2:0] ST_LOCKOUT      = 3'd2;
    localparam logic [2:0] ST_UNLOCKED     = 3'd3;
    localparam logic [2:0] ST_RELOCK       = 3'd4;
    localparam logic [2:0] ST_PROG_NEW     = 3'd5;
    localparam logic [2:0] ST_PROG_CONFIRM = 3'd6;

    localparam logic [7:0] KEY_ENTER = 8'd10;
    localparam logic [7:0] KEY_CLEAR = 8'd11;
    localparam logic [7:0] KEY_PROG  = 8'd12;

    // The actuator stays open while the stored code is being re-programmed.
    function automatic logic is_open(input logic [2:0] st);
        return (st == ST_UNLOCKED) || (st == ST_PROG_NEW) || (st == ST_PROG_CONFIRM);
    endfunction

    function automatic logic is_prog(input logic [2:0] st);
        return (st == ST_PROG_NEW) || (st == ST_PROG_CONFIRM);
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/keylock_press_edge_detect.sv
// Rising-edge detector for the button level; press is high on the first cycle a key is held.
module press_edge_detect (
    input  logic hwclk,
    input  logic rst_n,
    input  logic level,
    output logic press
);

    logic level_q_reg;

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            level_q_reg <= 1'b0;
        end else begin
            level_q_reg <= level;
        end
    end

    assign press = level & ~level_q_reg;

endmodule

// File: rtl/keylock_controller.sv
// Keypad lock sequencer: code check, failed-attempt lockout, auto-relock and
// two-step re-programming of the stored code.
module keylock_controller
    import keylock_pkg::*;
#(
    parameter logic [CODE_W-1:0] DEFAULT_CODE   = 32'd1234,
    parameter int                MAX_TRIES      = 3,
    parameter int                LOCKOUT_CYCLES = 24000000,
    parameter int                UNLOCK_CYCLES  = 60000000,
    parameter logic [7:0]        ENTER_KEY      = KEY_ENTER,
    parameter logic [7:0]        CLEAR_KEY      = KEY_CLEAR,
    parameter logic [7:0]        PROG_KEY       = KEY_PROG
) (
    input  logic              hwclk,
    input  logic              rst_n,
    input  logic [7:0]        key,
    input  logic              button_pressed,
    input  logic [CODE_W-1:0] typed,
    output logic              list_enable,
    output logic              unlocked,
    output logic              alarm,
    output logic              prog_mode,
    output logic [3:0]        fail_count
);

    logic [2:0]         state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [3:0]         fail_count_reg, fail_count_next;
    logic [CODE_W-1:0]  stored_code_reg, stored_code_next;
    logic [CODE_W-1:0]  pending_code_reg, pending_code_next;
    logic               pulse_reg;
    logic               clear_hit;
    logic               press, enter_press, clear_press, prog_press;
    logic               lock_done, open_done;

    press_edge_detect u_press (
        .hwclk (hwclk),
        .rst_n (rst_n),
        .level (button_pressed),
        .press (press)
    );

    assign enter_press = press && (key == ENTER_KEY);
    assign clear_press = press && (key == CLEAR_KEY);
    assign prog_press  = press && (key == PROG_KEY);
    assign lock_done   = (timer_reg == TIMER_W'(LOCKOUT_CYCLES - 1));
    assign open_done   = (timer_reg == TIMER_W'(UNLOCK_CYCLES - 1));

    always_comb begin
        state_next        = state_reg;
        timer_next        = '0;
        fail_count_next   = fail_count_reg;
        stored_code_next  = stored_code_reg;
        pending_code_next = pending_code_reg;
        clear_hit         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (enter_press) begin
                    state_next = ST_CHECK;
                end else if (clear_press) begin
                    clear_hit = 1'b1;
                end
            end
            ST_CHECK: begin
                if (typed == stored_code_reg) begin
                    state_next      = ST_UNLOCKED;
                    fail_count_next = '0;
                end else begin
                    fail_count_next = sat_inc4(fail_count_reg);
                    state_next = (int'(fail_count_next) >= MAX_TRIES) ? ST_LOCKOUT : ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                timer_next = timer_reg + TIMER_W'(1);
                if (lock_done) begin
                    state_next      = ST_IDLE;
                    fail_count_next = '0;
                end
            end
            // In the open states any key restarts the relock timer, but expiry beats a press.
            ST_UNLOCKED: begin
                timer_next = press ? '0 : timer_reg + TIMER_W'(1);
                if (open_done) begin
                    state_next = ST_RELOCK;
                end else if (prog_press) begin
                    state_next = ST_PROG_NEW;
                end else if (enter_press) begin
                    state_next = ST_RELOCK;
                end else if (clear_press) begin
                    clear_hit = 1'b1;
                end
            end
            ST_PROG_NEW: begin
                timer_next = press ? '0 : timer_reg + TIMER_W'(1);
                if (open_done) begin
                    state_next = ST_RELOCK;
                end else if (enter_press) begin
                    if (typed != '0) begin
                        pending_code_next = typed;
                        state_next        = ST_PROG_CONFIRM;
                    end else begin
                        clear_hit = 1'b1;
                    end
                end else if (clear_press) begin
                    state_next = ST_UNLOCKED;
                end
            end
            ST_PROG_CONFIRM: begin
                timer_next = press ? '0 : timer_reg + TIMER_W'(1);
                if (open_done) begin
                    state_next = ST_RELOCK;
                end else if (enter_press) begin
                    if (typed == pending_code_reg) begin
                        stored_code_next = pending_code_reg;
                    end
                    state_next = ST_UNLOCKED;
                end else if (clear_press) begin
                    state_next = ST_UNLOCKED;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (state_next != state_reg) begin
            timer_next = '0;
        end
    end

    // pulse_reg starts high so the accumulator is held clear straight out of reset.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            timer_reg        <= '0;
            fail_count_reg   <= '0;
            stored_code_reg  <= DEFAULT_CODE;
            pending_code_reg <= '0;
            pulse_reg        <= 1'b1;
        end else begin
            state_reg        <= state_next;
            timer_reg        <= timer_next;
            fail_count_reg   <= fail_count_next;
            stored_code_reg  <= stored_code_next;
            pending_code_reg <= pending_code_next;
            pulse_reg        <= (state_next != state_reg) || clear_hit;
        end
    end

    assign unlocked    = is_open(state_reg);
    assign prog_mode   = is_prog(state_reg);
    assign alarm       = (state_reg == ST_LOCKOUT);
    assign list_enable = (is_open(state_reg) || (state_reg == ST_IDLE)) && !pulse_reg;
    assign fail_count  = fail_count_reg;

endmodule

// File: tb/tb_keylock_controller.sv
// Bench for keylock_controller: attached accumulator, key-level reference model,
// directed scenarios followed by randomized key streams.
module tb_keylock_controller;

    localparam int         UNLOCK_T = 100;
    localparam int         LOCK_T   = 50;
    localparam int         TRIES    = 3;
    localparam logic [7:0] K_ENTER  = 8'd10;
    localparam logic [7:0] K_CLEAR  = 8'd11;
    localparam logic [7:0] K_PROG   = 8'd12;

    logic        hwclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  key = 8'd0;
    logic        button_pressed = 1'b0;
    logic [31:0] typed;
    logic        list_enable, unlocked, alarm, prog_mode;
    logic [3:0]  fail_count;
    logic        acc_prev;

    int checks = 0;
    int failures = 0;

    always #5 hwclk = ~hwclk;

    keylock_controller #(
        .DEFAULT_CODE   (32'd1234),
        .MAX_TRIES      (TRIES),
        .LOCKOUT_CYCLES (LOCK_T),
        .UNLOCK_CYCLES  (UNLOCK_T),
        .ENTER_KEY      (K_ENTER),
        .CLEAR_KEY      (K_CLEAR),
        .PROG_KEY       (K_PROG)
    ) dut (
        .hwclk          (hwclk),
        .rst_n          (rst_n),
        .key            (key),
        .button_pressed (button_pressed),
        .typed          (typed),
        .list_enable    (list_enable),
        .unlocked       (unlocked),
        .alarm          (alarm),
        .prog_mode      (prog_mode),
        .fail_count     (fail_count)
    );

    // Keypad accumulator: appends digits 1..6 on a press edge, cleared while enable is low.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            typed    <= 32'd0;
            acc_prev <= 1'b0;
        end else begin
            acc_prev <= button_pressed;
            if (!list_enable) begin
                typed <= 32'd0;
            end else if (button_pressed && !acc_prev && key >= 8'd1 && key <= 8'd6) begin
                typed <= typed * 32'd10 + 32'(key);
            end
        end
    end

    // Reference model at key-press granularity.
    typedef enum {M_CLOSED, M_OPEN, M_ENROLL, M_CONFIRM, M_ALARM} mode_t;
    mode_t       m_mode;
    logic [31:0] m_code, m_pending, m_buf;
    logic [3:0]  m_fails;
    int          m_quiet;
    logic        snap_le1, snap_ul1, snap_ul2;

    task automatic model_reset();
        m_mode = M_CLOSED; m_code = 32'd1234; m_pending = 32'd0;
        m_buf = 32'd0; m_fails = 4'd0; m_quiet = 0;
    endtask

    task automatic model_key(input logic [7:0] k);
        if (m_mode != M_ALARM) begin
            if (k >= 8'd1 && k <= 8'd6) begin
                m_buf = m_buf * 32'd10 + 32'(k);
            end else if (k == K_CLEAR) begin
                m_buf = 32'd0;
                if (m_mode == M_ENROLL || m_mode == M_CONFIRM) m_mode = M_OPEN;
            end else if (k == K_PROG && m_mode == M_OPEN) begin
                m_mode = M_ENROLL;
                m_buf = 32'd0;
            end else if (k == K_ENTER) begin
                case (m_mode)
                    M_CLOSED: begin
                        if (m_buf == m_code) begin
                            m_mode = M_OPEN; m_fails = 4'd0;
                        end else begin
                            m_fails = (m_fails == 4'd15) ? 4'd15 : m_fails + 4'd1;
                            if (int'(m_fails) >= TRIES) m_mode = M_ALARM;
                        end
                    end
                    M_OPEN:    m_mode = M_CLOSED;
                    M_ENROLL:  if (m_buf != 32'd0) begin m_pending = m_buf; m_mode = M_CONFIRM; end
                    M_CONFIRM: begin
                        if (m_buf == m_pending) m_code = m_pending;
                        m_mode = M_OPEN;
                    end
                    default: ;
                endcase
                m_buf = 32'd0;
            end
        end
        m_quiet = 3;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic op, pr;
        op = (m_mode == M_OPEN) || (m_mode == M_ENROLL) || (m_mode == M_CONFIRM);
        pr = (m_mode == M_ENROLL) || (m_mode == M_CONFIRM);
        check({tag, ":unlocked"},    32'(unlocked),    32'(op));
        check({tag, ":alarm"},       32'(alarm),       32'(m_mode == M_ALARM));
        check({tag, ":prog_mode"},   32'(prog_mode),   32'(pr));
        check({tag, ":fail_count"},  32'(fail_count),  32'(m_fails));
        check({tag, ":typed"},       typed,            m_buf);
        check({tag, ":list_enable"}, 32'(list_enable), 32'(m_mode != M_ALARM));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":unlocked"},    32'(unlocked),    32'd0);
        check({tag, ":alarm"},       32'(alarm),       32'd0);
        check({tag, ":prog_mode"},   32'(prog_mode),   32'd0);
        check({tag, ":fail_count"},  32'(fail_count),  32'd0);
        check({tag, ":list_enable"}, 32'(list_enable), 32'd0);
    endtask

    // One press: held two cycles, released, outputs checked 3.5 cycles after the press edge.
    task automatic press_key(input logic [7:0] k);
        @(negedge hwclk);
        key = k;
        button_pressed = 1'b1;
        @(negedge hwclk);
        snap_le1 = list_enable;
        snap_ul1 = unlocked;
        @(negedge hwclk);
        snap_ul2 = unlocked;
        button_pressed = 1'b0;
        repeat (2) @(negedge hwclk);
        model_key(k);
        $display("key=%0d typed=%0d unlocked=%0b alarm=%0b prog=%0b fails=%0d",
                 k, typed, unlocked, alarm, prog_mode, fail_count);
        check_model("key");
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge hwclk);
        m_quiet += n;
        if (m_quiet >= 105 && (m_mode == M_OPEN || m_mode == M_ENROLL || m_mode == M_CONFIRM)) begin
            m_mode = M_CLOSED;
            m_buf = 32'd0;
        end
        $display("idle=%0d unlocked=%0b typed=%0d", n, unlocked, typed);
        check_model("idle");
    endtask

    task automatic type_code(input logic [31:0] code);
        logic [7:0]  d[$];
        logic [31:0] v;
        v = code;
        while (v != 32'd0) begin
            d.push_front(8'(v % 32'd10));
            v = v / 32'd10;
        end
        foreach (d[i]) press_key(d[i]);
        press_key(K_ENTER);
    endtask

    task automatic ride_out_lockout();
        int n;
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) press_key(8'($urandom_range(1, 6)));
        repeat (55) @(negedge hwclk);
        m_mode = M_CLOSED; m_fails = 4'd0; m_buf = 32'd0; m_quiet = 100;
        $display("lockout over alarm=%0b fails=%0d", alarm, fail_count);
        check_model("lockout_end");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c1, c2;
        int unsigned r;

        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge hwclk);
        rst_n = 1'b1;
        @(negedge hwclk);
        check_model("post_reset");

        // Correct default code, CHECK lasts one cycle, then auto-relock clears the entry.
        press_key(8'd1); press_key(8'd2); press_key(8'd3); press_key(8'd4);
        press_key(K_ENTER);
        check("check_cycle_enable", 32'(snap_le1), 32'd0);
        check("check_cycle_locked", 32'(snap_ul1), 32'd0);
        check("open_after_check",   32'(snap_ul2), 32'd1);
        press_key(8'd1); press_key(8'd2);
        idle(110);
        check("relock_unlocked", 32'(unlocked), 32'd0);
        check("relock_typed",    typed,         32'd0);

        // CLEAR mid-entry.
        press_key(8'd1); press_key(8'd2); press_key(K_CLEAR);
        type_code(32'd1234);
        check("clear_then_open", 32'(unlocked), 32'd1);

        // Mismatched confirm and empty new code.
        press_key(K_PROG); type_code(32'd11); type_code(32'd22);
        check("mismatch_open", 32'(unlocked), 32'd1);
        check("mismatch_prog", 32'(prog_mode), 32'd0);
        press_key(K_PROG); press_key(K_ENTER);
        check("empty_stays_prog", 32'(prog_mode), 32'd1);
        press_key(K_CLEAR);
        press_key(K_ENTER);
        type_code(32'd1234);
        check("code_still_1234", 32'(unlocked), 32'd1);

        // Reprogram to 65.
        press_key(K_PROG); type_code(32'd65); type_code(32'd65);
        press_key(K_ENTER);
        type_code(32'd1234);
        check("old_code_fails", 32'(fail_count), 32'd1);
        type_code(32'd65);
        check("new_code_opens", 32'(unlocked), 32'd1);
        press_key(K_ENTER);

        // Lockout after three wrong codes.
        for (int i = 0; i < 3; i++) begin
            type_code(32'd55);
            check("lock_fail_count", 32'(fail_count), 32'(i + 1));
        end
        check("lock_alarm", 32'(alarm), 32'd1);
        press_key(8'd1); press_key(8'd2);
        ride_out_lockout();

        // Async reset mid-lockout.
        for (int i = 0; i < 3; i++) type_code(32'd55);
        press_key(8'd3);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_lockout");
        @(negedge hwclk);
        rst_n = 1'b1;
        model_reset();
        @(negedge hwclk);
        check_model("after_rst_lockout");
        type_code(32'd1234);
        check("rst_code_default", 32'(unlocked), 32'd1);

        // Async reset in PROG_CONFIRM with a non-default stored code.
        press_key(K_PROG); type_code(32'd65); type_code(32'd65);
        press_key(K_ENTER);
        type_code(32'd65);
        press_key(K_PROG); type_code(32'd33);
        check("in_confirm", 32'(prog_mode), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_confirm");
        @(negedge hwclk);
        rst_n = 1'b1;
        model_reset();
        @(negedge hwclk);
        type_code(32'd1234);
        check("rst_code_reverts", 32'(unlocked), 32'd1);

        // Randomized key streams against the model.
        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                press_key(8'($urandom_range(0, 12)));
            end else if (r < 65) begin
                type_code(m_code);
            end else if (r < 80) begin
                c1 = 32'($urandom_range(1, 6)) * 32'd10 + 32'($urandom_range(1, 6));
                c2 = ($urandom_range(0, 1) == 0) ? c1 : 32'($urandom_range(11, 66));
                press_key(K_PROG);
                type_code(c1);
                type_code(c2);
            end else if (r < 90 || m_quiet + 10 > 80) begin
                idle(110);
            end else begin
                idle(10);
            end
            if (m_mode == M_ALARM) ride_out_lockout();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keylock_controller.md
Name: keylock_controller

Overview:
- Sequences the keypad code accumulator. Gates its enable, detects ENTER, CLEAR and PROG keys, and compares the accumulated code against a stored code.
- Drives the lock output and tracks failed attempts, with timed lockout.
- Supports re-programming the stored code with double entry.
- Sits between the keypad decoder (key, button_pressed) and the accumulator (enable in, typed out).

Parameters:
- DEFAULT_CODE, 32'd1234, stored code after reset.
- MAX_TRIES, 3, consecutive failures that trigger lockout (1..15).
- LOCKOUT_CYCLES, 24000000, lockout duration in hwclk cycles (2 s at 12 MHz).
- UNLOCK_CYCLES, 60000000, auto-relock timeout in hwclk cycles (5 s).
- ENTER_KEY, 8'd10, key code for submit.
- CLEAR_KEY, 8'd11, key code for clearing the current entry.
- PROG_KEY, 8'd12, key code for programming mode (accepted only while unlocked).

Ports:
- hwclk, in, 1, system clock (12 MHz).
- rst_n, in, 1, asynchronous active-low reset.
- key, in, 8, current keypad code; valid while button_pressed=1.
- button_pressed, in, 1, level, high while a key is held.
- typed, in, 32, accumulated decimal code from the accumulator.
- list_enable, out, 1, accumulator enable; low for ≥1 cycle clears the accumulator.
- unlocked, out, 1, lock actuator; 1 means open.
- alarm, out, 1, high during lockout.
- prog_mode, out, 1, high in PROG_NEW/PROG_CONFIRM.
- fail_count, out, 4, consecutive failed attempts.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, list_enable=0, unlocked=0, alarm=0, prog_mode=0, fail_count=0.
  - stored_code=DEFAULT_CODE, pending_code=0, timer=0, press edge register=0.
- Press event: press=button_pressed & !pressed_q, registered one flop. Evaluated on the same cycle the accumulator sees the edge.
  - Command keys (ENTER/CLEAR/PROG) are not digits 1..6, so the accumulator ignores them. The controller samples typed on that cycle; it is stable because no digit was added.
- list_enable is 1 in IDLE, UNLOCKED, PROG_NEW and PROG_CONFIRM, except for a one-cycle low pulse ("clear pulse") on the cycle after any transition or CLEAR press. It is 0 in CHECK, LOCKOUT and RELOCK.
- States and transitions (one transition per cycle; all on the rising edge of hwclk):
  - IDLE:
    - press & key==CLEAR → clear pulse, stay.
    - press & key==ENTER → CHECK.
    - Other keys: no action by the controller.
  - CHECK (1 cycle):
    - typed==stored_code → UNLOCKED: fail_count=0, unlocked=1, timer=0.
    - Otherwise fail_count+1. If the new count ≥ MAX_TRIES → LOCKOUT (alarm=1, timer=0); else → IDLE with a clear pulse.
  - LOCKOUT:
    - timer counts up; all presses are ignored.
    - timer==LOCKOUT_CYCLES-1 → IDLE: alarm=0, fail_count=0, clear pulse.
  - UNLOCKED:
    - timer counts up and restarts at 0 on any press.
    - press & key==PROG → PROG_NEW: prog_mode=1, clear pulse.
    - press & key==ENTER → RELOCK.
    - timer==UNLOCK_CYCLES-1 → RELOCK.
  - RELOCK (1 cycle): unlocked=0 → IDLE with a clear pulse.
  - PROG_NEW:
    - press & ENTER with typed≠0 → latch pending_code=typed → PROG_CONFIRM, clear pulse.
    - ENTER with typed==0 → stay, clear pulse (empty code rejected).
    - CLEAR → UNLOCKED: prog_mode=0, clear pulse, stored_code unchanged.
  - PROG_CONFIRM:
    - press & ENTER: if typed==pending_code, stored_code=pending_code. In both cases → UNLOCKED with timer=0, prog_mode=0 and a clear pulse.
    - CLEAR → UNLOCKED with stored_code unchanged.
- unlocked stays 1 throughout PROG_NEW and PROG_CONFIRM. The auto-relock timer runs in the PROG states too; on expiry → RELOCK and prog_mode=0, with stored_code unchanged.
- Simultaneous events: a press on the same cycle as timer expiry means expiry wins (press ignored).
- fail_count saturates at 15.
- The timer is 26 bits wide; compare equality only.
- Reset mid-operation: all state returns to reset values, including reversion of stored_code to DEFAULT_CODE.

Decomposition:
- Shared package keylock_pkg:
  - state encoding localparams (IDLE, CHECK, LOCKOUT, UNLOCKED, RELOCK, PROG_NEW, PROG_CONFIRM; 3-bit);
  - default key codes ENTER/CLEAR/PROG;
  - CODE_W=32.
- One sub-module: press_edge_detect (register plus rising-edge pulse). It is reusable by the accumulator path.
- The timer stays inline.

Test Plan:
- Correct code: reset, press 1,2,3,4, ENTER (accumulator model attached) → CHECK for 1 cycle, then unlocked=1 and fail_count=0. After UNLOCK_CYCLES (override to 100), unlocked=0 and list_enable has pulsed low.
- Lockout: MAX_TRIES=3, LOCKOUT_CYCLES=50. Enter 9-free wrong code 5,5, ENTER three times → fail_count 1,2,3 and alarm=1. Digit presses during alarm are ignored. After 50 cycles alarm=0 and fail_count=0.
- Reprogram: unlock, PROG, 6,5, ENTER, 6,5, ENTER → stored_code=65. Relock, then 1,2,3,4 ENTER fails and 6,5 ENTER unlocks.
- Mismatched confirm: PROG, 1,1, ENTER, 2,2, ENTER → back in UNLOCKED with stored_code still 1234. Also PROG, ENTER with typed=0 → stays in PROG_NEW.
- CLEAR mid-entry: 1,2, CLEAR, 1,2,3,4, ENTER → unlocks (typed cleared to 0 by the enable pulse).
- Async reset: assert rst_n=0 mid-LOCKOUT and while in PROG_CONFIRM → all outputs 0 immediately without a clock edge; stored_code returns to 1234 after release.
